// File: rtl/genx_qspi_txn_tracker.sv
// QSPI transaction tracker: synchronises SCK-domain notifies, times each
// transaction and queues one record per transaction in a FWFT FIFO.
module genx_qspi_txn_tracker #(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int DUR_W          = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          dbg_notify_read,
    output logic                          dbg_notify_write,
    input  logic [9:0]                    sck_counts,
    input  logic [7:0]                    opcode,
    input  logic [31:0]                   address,
    input  logic [1:0]                    chip_select,
    input  logic                          async_notify_read,
    input  logic                          async_notify_write,
    output logic [DUR_W+53:0]             rec_tdata,
    output logic                          rec_tvalid,
    input  logic                          rec_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_count,
    output logic                          busy
);
    localparam int RW    = DUR_W + 54;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_N = ARM_W'(SYNC_STAGES + 1);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    // Timeout threshold clamps to all-ones when it does not fit the field.
    localparam logic [DUR_W-1:0] TO_SAT =
        ((64'(TIMEOUT_CYCLES) >> DUR_W) != 64'd0) ? {DUR_W{1'b1}}
                                                   : DUR_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, WAIT_END} state_t;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] rd_sync_q;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] rd_sync_d, wr_sync_d;
    logic rd_prev_q, wr_prev_q, rd_rise_q, wr_rise_q;
    logic rd_rise_d, wr_rise_d, armed;
    logic [ARM_W-1:0] arm_q, arm_d;

    state_t state_q, state_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [7:0] op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0] cs_q, cs_d;
    logic push;
    logic [RW-1:0] push_rec;

    logic [RW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [15:0] drop_q, drop_d;
    logic full, pop, wr_en, drop_inc;

    always_comb begin
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], async_notify_read};
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], async_notify_write};
        armed     = (arm_q == ARM_N);
        arm_d     = armed ? arm_q : arm_q + 1'b1;
        // Prior-value regs track the chain even while disarmed, so a
        // notify already high out of reset never looks like an edge.
        rd_rise_d = rd_sync_q[SYNC_STAGES-1] & ~rd_prev_q & armed;
        wr_rise_d = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q & armed;
    end

    always_comb begin
        state_d  = state_q;
        dur_d    = dur_q;
        op_d     = op_q;
        addr_d   = addr_q;
        cs_d     = cs_q;
        push     = 1'b0;
        push_rec = '0;
        unique case (state_q)
            IDLE: begin
                if (rd_rise_q && wr_rise_q) begin
                    push     = 1'b1;
                    push_rec = {{DUR_W{1'b0}}, 2'b00, sck_counts,
                                chip_select, opcode, address};
                end else if (rd_rise_q) begin
                    op_d    = opcode;
                    addr_d  = address;
                    cs_d    = chip_select;
                    dur_d   = '0;
                    state_d = WAIT_END;
                end else if (wr_rise_q) begin
                    push     = 1'b1;
                    push_rec = {{DUR_W{1'b0}}, 2'b01, sck_counts, 42'd0};
                end
            end
            WAIT_END: begin
                dur_d = (&dur_q) ? dur_q : dur_q + 1'b1;
                if (wr_rise_q) begin
                    push     = 1'b1;
                    push_rec = {dur_q, 2'b00, sck_counts, cs_q, op_q, addr_q};
                    state_d  = IDLE;
                end else if (rd_rise_q) begin
                    push     = 1'b1;
                    push_rec = {dur_q, 2'b10, 10'd0, cs_q, op_q, addr_q};
                    op_d     = opcode;
                    addr_d   = address;
                    cs_d     = chip_select;
                    dur_d    = '0;
                end else if (dur_q == TO_SAT) begin
                    push     = 1'b1;
                    push_rec = {TO_SAT, 2'b10, 10'd0, cs_q, op_q, addr_q};
                    state_d  = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        full     = (cnt_q == DEPTH_C);
        pop      = rec_tvalid & rec_tready;
        // A pop frees the full slot in the same cycle, so push still lands.
        wr_en    = push & (~full | pop);
        drop_inc = push & full & ~pop;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        drop_d   = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sync_q <= '0;
            wr_sync_q <= '0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            rd_rise_q <= 1'b0;
            wr_rise_q <= 1'b0;
            arm_q     <= '0;
            state_q   <= IDLE;
            dur_q     <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            cs_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
        end else begin
            rd_sync_q <= rd_sync_d;
            wr_sync_q <= wr_sync_d;
            rd_prev_q <= rd_sync_q[SYNC_STAGES-1];
            wr_prev_q <= wr_sync_q[SYNC_STAGES-1];
            rd_rise_q <= rd_rise_d;
            wr_rise_q <= wr_rise_d;
            arm_q     <= arm_d;
            state_q   <= state_d;
            dur_q     <= dur_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_rec;
    end

    assign rec_tvalid       = (cnt_q != '0);
    assign rec_tdata        = rec_tvalid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count       = cnt_q;
    assign drop_count       = drop_q;
    assign busy             = (state_q == WAIT_END);
    assign dbg_notify_read  = rd_rise_q;
    assign dbg_notify_write = wr_rise_q;

endmodule

// File: tb/tb_genx_qspi_txn_tracker.sv
// Directed bench for genx_qspi_txn_tracker with a record scoreboard;
// a second instance with a short timeout covers the timeout path.
module tb_genx_qspi_txn_tracker;
    localparam int DUR_W = 24;
    localparam int RW    = DUR_W + 54;

    typedef struct {
        logic [RW-1:0] rec;
        int            tol;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, anr, anw, rec_tready, to_tready;
    logic [9:0] sck_counts;
    logic [7:0] opcode;
    logic [31:0] address;
    logic [1:0] chip_select;
    logic dbg_rd, dbg_wr, rec_tvalid, busy;
    logic [RW-1:0] rec_tdata;
    logic [4:0] fifo_count;
    logic [15:0] drop_count;
    logic to_dbg_rd, to_dbg_wr, to_tvalid, to_busy;
    logic [RW-1:0] to_tdata;
    logic [4:0] to_fifo_count;
    logic [15:0] to_drop;

    exp_t exp_q[$];
    logic [RW-1:0] to_log[$];
    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    bit bp_mode = 1'b0;

    genx_qspi_txn_tracker dut (
        .clk(clk), .reset(reset),
        .dbg_notify_read(dbg_rd), .dbg_notify_write(dbg_wr),
        .sck_counts(sck_counts), .opcode(opcode), .address(address),
        .chip_select(chip_select),
        .async_notify_read(anr), .async_notify_write(anw),
        .rec_tdata(rec_tdata), .rec_tvalid(rec_tvalid),
        .rec_tready(rec_tready), .fifo_count(fifo_count),
        .drop_count(drop_count), .busy(busy)
    );

    genx_qspi_txn_tracker #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .reset(reset),
        .dbg_notify_read(to_dbg_rd), .dbg_notify_write(to_dbg_wr),
        .sck_counts(sck_counts), .opcode(opcode), .address(address),
        .chip_select(chip_select),
        .async_notify_read(anr), .async_notify_write(anw),
        .rec_tdata(to_tdata), .rec_tvalid(to_tvalid),
        .rec_tready(to_tready), .fifo_count(to_fifo_count),
        .drop_count(to_drop), .busy(to_busy)
    );

    function automatic logic [RW-1:0] mk(input int dur, input bit tmo,
        input bit nh, input logic [9:0] sck, input logic [1:0] cs,
        input logic [7:0] op, input logic [31:0] ad);
        return {DUR_W'(dur), tmo, nh, sck, cs, op, ad};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs,
                         input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        int d, ed;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_rec: observed %0h expected none", rec_tdata);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rec_fields", 96'(rec_tdata[53:0]), 96'(e.rec[53:0]));
            d  = int'(rec_tdata[RW-1:54]);
            ed = int'(e.rec[RW-1:54]);
            checks++;
            assert (d >= ed - e.tol && d <= ed + e.tol) else begin
                errors++;
                $error("FAIL rec_dur: observed %0d expected %0d+-%0d",
                       d, ed, e.tol);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rec_tvalid && rec_tready) check_pop();
        if (to_tvalid) to_log.push_back(to_tdata);
        if (dbg_rd) rd_pulses++;
        if (dbg_wr) wr_pulses++;
        @(posedge clk);
        #1;
        if (bp_mode) rec_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_exp(input logic [RW-1:0] r, input int tol);
        exp_t e;
        e.rec = r;
        e.tol = tol;
        exp_q.push_back(e);
    endtask

    task automatic txn(input logic [7:0] op, input logic [31:0] ad,
        input logic [1:0] cs, input logic [9:0] sck, input int gap,
        input bit keep, input int tol);
        opcode = op;
        address = ad;
        chip_select = cs;
        anr = 1'b1;
        repeat (gap) tick();
        sck_counts = sck;
        anw = 1'b1;
        if (keep) push_exp(mk(gap, 1'b0, 1'b0, sck, cs, op, ad), tol);
        repeat (8) tick();
        anr = 1'b0;
        anw = 1'b0;
        repeat (6) tick();
        check("fifo_count_vs_sb", 96'(fifo_count), 96'(exp_q.size()));
    endtask

    task automatic drain();
        int n = 0;
        bp_mode = 1'b0;
        rec_tready = 1'b1;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check("drain_sb_empty", 96'(exp_q.size()), 96'(0));
        check("drain_fifo_count", 96'(fifo_count), 96'(0));
        check("drain_tvalid", 96'(rec_tvalid), 96'(0));
    endtask

    initial begin
        logic [RW-1:0] r;
        int n;
        reset = 1'b1;
        anr = 1'b0;
        anw = 1'b0;
        sck_counts = '0;
        opcode = '0;
        address = '0;
        chip_select = '0;
        rec_tready = 1'b1;
        to_tready = 1'b1;
        repeat (4) tick();
        check("rst_tvalid", 96'(rec_tvalid), 96'(0));
        check("rst_tdata", 96'(rec_tdata), 96'(0));
        check("rst_fifo_count", 96'(fifo_count), 96'(0));
        check("rst_drop", 96'(drop_count), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_dbg", 96'({dbg_rd, dbg_wr}), 96'(0));
        reset = 1'b0;
        repeat (8) tick();

        // normal transaction
        rd_pulses = 0;
        wr_pulses = 0;
        txn(8'hEB, 32'h0012_3400, 2'b01, 10'd80, 500, 1'b1, 2);
        drain();
        check("norm_rd_pulses", 96'(rd_pulses), 96'(1));
        check("norm_wr_pulses", 96'(wr_pulses), 96'(1));
        check("norm_busy", 96'(busy), 96'(0));

        // simultaneous edges
        txn(8'h9F, 32'hDEAD_0004, 2'b11, 10'd17, 0, 1'b1, 0);
        drain();

        // overflow: 18 transactions, no consumer
        rec_tready = 1'b0;
        for (int i = 0; i < 18; i++)
            txn(8'(8'h10 + i), 32'h1000_0000 + 32'(i * 16), 2'(i), 10'(i + 3),
                4 + (i % 5), i < 16, 2);
        check("ovf_fifo_count", 96'(fifo_count), 96'(16));
        check("ovf_drop_count", 96'(drop_count), 96'(2));
        drain();

        // timeout on the short-timeout instance
        to_log.delete();
        opcode = 8'h03;
        address = 32'hA5A5_0000;
        chip_select = 2'b10;
        anr = 1'b1;
        n = 0;
        while (to_log.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        check("to_rec_seen", 96'(to_log.size()), 96'(1));
        check("to_latency_ok", 96'(n >= 100 && n <= 112), 96'(1));
        if (to_log.size() != 0) begin
            r = to_log.pop_front();
            check("to_rec", 96'(r),
                  96'(mk(100, 1'b1, 1'b0, 10'd0, 2'b10, 8'h03, 32'hA5A5_0000)));
        end
        repeat (5) tick();
        check("to_busy_after", 96'(to_busy), 96'(0));
        check("main_busy_wait", 96'(busy), 96'(1));
        sck_counts = 10'h55;
        anw = 1'b1;
        push_exp(mk(n + 5, 1'b0, 1'b0, 10'h55, 2'b10, 8'h03, 32'hA5A5_0000), 2);
        repeat (8) tick();
        check("to_nohdr_seen", 96'(to_log.size()), 96'(1));
        if (to_log.size() != 0) begin
            r = to_log.pop_front();
            check("to_nohdr_rec", 96'(r),
                  96'(mk(0, 1'b0, 1'b1, 10'h55, 2'b00, 8'h00, 32'h0)));
        end
        anr = 1'b0;
        anw = 1'b0;
        repeat (6) tick();
        drain();

        // notify held high through reset release
        reset = 1'b1;
        anr = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rd_pulses = 0;
        repeat (12) tick();
        check("arm_no_dbg", 96'(rd_pulses), 96'(0));
        check("arm_busy", 96'(busy), 96'(0));
        check("arm_no_rec", 96'(fifo_count), 96'(0));
        check("arm_drop_clr", 96'(drop_count), 96'(0));
        anr = 1'b0;
        repeat (6) tick();

        // reset mid-WAIT_END with 3 records queued
        rec_tready = 1'b0;
        for (int i = 0; i < 3; i++)
            txn(8'(8'hC0 + i), 32'h2000_0000 + 32'(i), 2'b01, 10'd9, 6, 1'b1, 2);
        opcode = 8'h77;
        anr = 1'b1;
        repeat (8) tick();
        check("mid_busy", 96'(busy), 96'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_tvalid", 96'(rec_tvalid), 96'(0));
        check("mid_rst_count", 96'(fifo_count), 96'(0));
        check("mid_rst_busy", 96'(busy), 96'(0));
        exp_q.delete();
        anr = 1'b0;
        repeat (8) tick();
        rec_tready = 1'b1;

        // random backpressure
        bp_mode = 1'b1;
        for (int i = 0; i < 50; i++)
            txn(8'($urandom), $urandom, 2'($urandom), 10'($urandom),
                int'($urandom_range(1, 15)), 1'b1, 2);
        drain();
        check("bp_drop", 96'(drop_count), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/genx_qspi_txn_tracker.md
Name: genx_qspi_txn_tracker

Overview:
- Successor to the QSPI simulator's notify handler.
- Synchronises the async header-arrived and chip-select-deasserted notifies from the SCK domain, and tracks each QSPI transaction through a small state machine.
- Captures one record per transaction: opcode, address, chip-selects, SCK count, duration in clk cycles, and flags.
- Queues records in a parametrised FWFT FIFO, read out over a valid/ready stream by the register/ILA side. Keeps the single-cycle debug pulses.

Parameters:
- SYNC_STAGES, 2, flop stages per async notify synchroniser (2..4).
- FIFO_DEPTH, 16, record FIFO depth; power of 2, 2..256.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed from header notify to end notify.
- DUR_W, 24, width of the duration field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dbg_notify_read  out  1  one-cycle pulse on synced read-notify rising edge.
- dbg_notify_write  out  1  one-cycle pulse on synced write-notify rising edge.
- sck_counts  in  10  SCK rising-edge count; quasi-static while async_notify_write is high.
- opcode  in  8  opcode from MOSI; quasi-static while async_notify_read is high.
- address  in  32  address from MOSI; same stability as opcode.
- chip_select  in  2  active chip-selects; same stability as opcode.
- async_notify_read  in  1  rising edge = header (cs, opcode, address) arrived.
- async_notify_write  in  1  rising edge = chip-select de-asserted.
- rec_tdata  out  DUR_W+54  head record.
- rec_tvalid  out  1  FIFO non-empty.
- rec_tready  in  1  consumer accepts head record.
- fifo_count  out  clog2(FIFO_DEPTH)+1  records held.
- drop_count  out  16  records lost to a full FIFO; saturating.
- busy  out  1  state == WAIT_END.

Behaviour:
- Record layout:
  - [DUR_W+53:54] duration
  - [53] timeout
  - [52] no_header
  - [51:42] sck_counts
  - [41:40] chip_select
  - [39:32] opcode
  - [31:0] address
- Synchronisers:
  - Inferred flop chains of SYNC_STAGES with ASYNC_REG, cleared by reset.
  - Prior-value registers give rising edges rd_rise / wr_rise, one cycle wide.
- Edge latency: async edge to rd_rise/wr_rise is SYNC_STAGES+1 clk (±1 for metastability).
- Post-reset arming: edge detection is masked for SYNC_STAGES+1 cycles after reset deasserts. A notify already high out of reset produces no edge and no record.
- dbg outputs equal rd_rise / wr_rise.
- State IDLE:
  - On rd_rise: latch opcode, address and chip_select; clear the duration counter; go to WAIT_END.
  - On wr_rise without rd_rise: push a record with no_header=1, address/opcode/cs=0, duration=0, current sck_counts. Stay in IDLE.
- State WAIT_END:
  - Duration increments each cycle and saturates at all-ones.
  - On wr_rise: push a record with latched header, current sck_counts, duration, flags 0. Go to IDLE.
  - If duration reaches TIMEOUT_CYCLES before wr_rise: push a record with timeout=1, sck_counts=0, duration=TIMEOUT_CYCLES (saturated if wider than DUR_W). Go to IDLE.
  - A later wr_rise then yields a no_header record.
- Same-cycle events:
  - rd_rise and wr_rise together in IDLE: push one complete record, duration 0, flags 0.
  - rd_rise in WAIT_END (new header, no end): push the old header as timeout=1 with its current duration, relatch the new header, stay in WAIT_END.
  - wr_rise and timeout in the same cycle: wr_rise wins.
- FIFO:
  - First-word fall-through; a push is visible on rec_tvalid the next cycle.
  - Pop when rec_tvalid & rec_tready.
  - Push and pop in the same cycle are both honoured at any occupancy, including full.
  - Push while full without a pop: record dropped, drop_count += 1 (saturates at 65535), FIFO contents unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- Reset values:
  - rec_tvalid=0, rec_tdata=0, fifo_count=0, drop_count=0, busy=0, dbg outputs 0.
  - State IDLE; FIFO emptied.
  - Reset mid-transaction discards the in-flight header and all queued records.

Test Plan:
- Normal transaction: opcode=0xEB, address=0x00123400, chip_select=2'b01; raise async_notify_read; 500 cycles later set sck_counts=10'd80 and raise async_notify_write. Expect exactly one record: opcode EB, address 00123400, cs 01, sck 80, duration 500±2, flags 0; one dbg pulse of each kind.
- Overflow: 18 transactions with rec_tready=0, FIFO_DEPTH=16. Expect fifo_count=16, drop_count=2; drain yields the first 16 records in order, addresses intact.
- Timeout: TIMEOUT_CYCLES=100; raise read notify only. Expect a record with timeout=1 and duration=100 about 100 cycles after rd_rise, busy low afterwards. A later write notify yields a no_header=1 record.
- Simultaneous edges: both async notifies rise in the same cycle. Expect one record with duration 0 and flags 0.
- Reset: async_notify_read held high through reset release → no record, no dbg pulse. Assert reset mid-WAIT_END with 3 records queued → rec_tvalid=0 and fifo_count=0 next cycle.
- Backpressure: toggle rec_tready randomly across 50 transactions. Expect record order preserved, no duplicates or losses, and fifo_count consistent with accepted pops.
